// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage: FSM states, load
// width codes, store size masks and fault encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_B = 4'h1;
  localparam logic [3:0] MASK_H = 4'h3;
  localparam logic [3:0] MASK_W = 4'hF;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;

  // Loads take their access size from func3[1:0] (00 byte, 01 half, else word);
  // stores take it from the size mask.
  function automatic logic misaligned(input logic       is_load,
                                      input logic [2:0] f3,
                                      input logic [3:0] mask,
                                      input logic [1:0] addr_lo);
    logic half, word;
    if (is_load) begin
      half = (f3[1:0] == 2'b01);
      word = (f3[1:0] == 2'b10) || (f3[1:0] == 2'b11);
    end else begin
      half = (mask == MASK_H);
      word = (mask == MASK_W);
    end
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response port; master is the LSU, slave is the memory.
interface lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational extraction of a byte/half/word from a read word, with sign or
// zero extension selected by the load's func3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (func3_i)
      F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{16{half_v[15]}}, half_v};
      F3_LBU:  data_o = {24'h0, byte_v};
      F3_LHU:  data_o = {16'h0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: accepts one instruction from execute, runs at most one
// memory transaction, and holds the result until write-back takes it.
module lsu
  import lsu_pkg::*;
#(
  parameter int WB_W = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in_exu,
  output logic            ready_out_exu,
  input  logic [31:0]     alu_out,
  input  logic [31:0]     wdata,
  input  logic [7:0]      wmask,
  input  logic            mem_ren,
  input  logic            mem_wen,
  input  logic [2:0]      func3,
  input  logic [WB_W-1:0] wb_info,
  lsu_if.master           mem,
  output logic            valid_out_wbu,
  input  logic            ready_in_wbu,
  output logic [31:0]     result_buf,
  output logic [WB_W-1:0] wb_info_buf,
  output logic [1:0]      fault_buf
);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;
  logic            store_q, store_d;
  logic [2:0]      func3_q, func3_d;
  logic [WB_W-1:0] wb_q, wb_d;
  logic [31:0]     result_q, result_d;
  logic [1:0]      fault_q, fault_d;
  logic [31:0]     load_data;
  logic            unused_wmask_hi;

  assign unused_wmask_hi = ^wmask[7:4];

  lsu_load_align u_align (
    .func3_i   (func3_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (mem.mem_resp_rdata),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      store_q  <= 1'b0;
      func3_q  <= '0;
      wb_q     <= '0;
      result_q <= '0;
      fault_q  <= FAULT_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      store_q  <= store_d;
      func3_q  <= func3_d;
      wb_q     <= wb_d;
      result_q <= result_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    store_d  = store_q;
    func3_d  = func3_q;
    wb_d     = wb_q;
    result_d = result_q;
    fault_d  = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in_exu) begin
          addr_d   = alu_out;
          wdata_d  = wdata;
          mask_d   = wmask[3:0];
          store_d  = mem_wen;
          func3_d  = func3;
          wb_d     = wb_info;
          // Default result is alu_out: final for non-memory ops and stores,
          // and the faulting address for misaligned accesses.
          result_d = alu_out;
          fault_d  = FAULT_NONE;
          if (!(mem_ren || mem_wen)) begin
            state_d = ST_WAIT;
          end else if (misaligned(!mem_wen, func3, wmask[3:0], alu_out[1:0])) begin
            fault_d = FAULT_MISALIGN;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (mem.mem_resp_valid) begin
          state_d = ST_WAIT;
          if (mem.mem_resp_err) begin
            fault_d  = FAULT_ACCESS;
            result_d = '0;
          end else if (!store_q) begin
            result_d = load_data;
          end
        end
      end
      ST_WAIT: begin
        if (ready_in_wbu) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_out_exu = (state_q == ST_IDLE);
  assign valid_out_wbu = (state_q == ST_WAIT);
  assign result_buf    = result_q;
  assign wb_info_buf   = wb_q;
  assign fault_buf     = fault_q;

  // Request fields come only from latched state so they stay stable across stalls.
  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_req_wen   = store_q;
  assign mem.mem_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign mem.mem_req_wstrb = mask_q << addr_q[1:0];

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store stage with a hand-driven memory port.
module tb_lsu;
  localparam int WB_W = 128;

  logic            clk;
  logic            rst;
  logic            valid_in_exu;
  logic            ready_out_exu;
  logic [31:0]     alu_out;
  logic [31:0]     wdata;
  logic [7:0]      wmask;
  logic            mem_ren;
  logic            mem_wen;
  logic [2:0]      func3;
  logic [WB_W-1:0] wb_info;
  logic            valid_out_wbu;
  logic            ready_in_wbu;
  logic [31:0]     result_buf;
  logic [WB_W-1:0] wb_info_buf;
  logic [1:0]      fault_buf;

  int checks;
  int failures;

  lsu_if mem_bus ();

  lsu #(.WB_W(WB_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in_exu  (valid_in_exu),
    .ready_out_exu (ready_out_exu),
    .alu_out       (alu_out),
    .wdata         (wdata),
    .wmask         (wmask),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .func3         (func3),
    .wb_info       (wb_info),
    .mem           (mem_bus),
    .valid_out_wbu (valid_out_wbu),
    .ready_in_wbu  (ready_in_wbu),
    .result_buf    (result_buf),
    .wb_info_buf   (wb_info_buf),
    .fault_buf     (fault_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp);
    valid_in_exu = 1'b1; alu_out = addr; mem_ren = 1'b1; mem_wen = 1'b0;
    func3 = f3; wmask = 8'h0F; ready_in_wbu = 1'b1;
    mem_bus.mem_req_ready = 1'b1;
    tick();
    valid_in_exu = 1'b0;
    chk({tag, "_reqv"}, mem_bus.mem_req_valid, 1'b1);
    chk({tag, "_addr"}, mem_bus.mem_req_addr, {addr[31:2], 2'b00});
    tick();
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = rd;
    chk({tag, "_vout_early"}, valid_out_wbu, 1'b0);
    tick();
    mem_bus.mem_resp_valid = 1'b0;
    chk({tag, "_vout"}, valid_out_wbu, 1'b1);
    chk({tag, "_result"}, result_buf, exp);
    chk({tag, "_fault"}, fault_buf, 2'b00);
    tick();
    chk({tag, "_idle"}, ready_out_exu, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    valid_in_exu = 1'b0; alu_out = '0; wdata = '0; wmask = '0;
    mem_ren = 1'b0; mem_wen = 1'b0; func3 = '0; wb_info = '0; ready_in_wbu = 1'b0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_rdata = '0; mem_bus.mem_resp_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_out_exu, 1'b1);
    chk("rst_vout", valid_out_wbu, 1'b0);
    chk("rst_reqv", mem_bus.mem_req_valid, 1'b0);
    chk("rst_result", result_buf, 32'h0);
    chk("rst_fault", fault_buf, 2'b00);
    chk("rst_wb", wb_info_buf, 128'h0);
    rst = 1'b1;
    tick();

    // Non-memory op: result is alu_out, valid for exactly one cycle
    valid_in_exu = 1'b1; alu_out = 32'h1234_5678; ready_in_wbu = 1'b1;
    wb_info = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    valid_in_exu = 1'b0;
    chk("alu_vout", valid_out_wbu, 1'b1);
    chk("alu_ready", ready_out_exu, 1'b0);
    chk("alu_result", result_buf, 32'h1234_5678);
    chk("alu_wb", wb_info_buf, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("alu_noreq", mem_bus.mem_req_valid, 1'b0);
    tick();
    chk("alu_vout_drop", valid_out_wbu, 1'b0);
    chk("alu_ready_back", ready_out_exu, 1'b1);

    // Loads with zero-wait memory
    run_load("lb",  3'b000, 32'h8000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h8000_0003, 32'h80AA_BBCC, 32'h0000_0080);
    run_load("lh",  3'b001, 32'h8000_0002, 32'h80AA_BBCC, 32'hFFFF_80AA);
    run_load("lhu", 3'b101, 32'h8000_0002, 32'h80AA_BBCC, 32'h0000_80AA);
    run_load("lbl", 3'b000, 32'h8000_0000, 32'h80AA_BB7C, 32'h0000_007C);
    run_load("lw",  3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Store half at offset 2; upper mask bits are ignored; write-back stalls a cycle
    valid_in_exu = 1'b1; alu_out = 32'h8000_0002; wdata = 32'h0000_BEEF; wmask = 8'hF3;
    mem_ren = 1'b0; mem_wen = 1'b1; func3 = 3'b001; ready_in_wbu = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    tick();
    valid_in_exu = 1'b0;
    chk("sh_reqv", mem_bus.mem_req_valid, 1'b1);
    chk("sh_addr", mem_bus.mem_req_addr, 32'h8000_0000);
    chk("sh_wen", mem_bus.mem_req_wen, 1'b1);
    chk("sh_wstrb", mem_bus.mem_req_wstrb, 4'b1100);
    chk("sh_wdata", mem_bus.mem_req_wdata, 32'hBEEF_0000);
    tick();
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'h5555_5555;
    tick();
    mem_bus.mem_resp_valid = 1'b0;
    chk("sh_vout", valid_out_wbu, 1'b1);
    chk("sh_result", result_buf, 32'h8000_0002);
    tick();
    chk("sh_hold_vout", valid_out_wbu, 1'b1);
    chk("sh_hold_result", result_buf, 32'h8000_0002);
    ready_in_wbu = 1'b1;
    tick();
    chk("sh_idle", ready_out_exu, 1'b1);

    // Misaligned word load: no request, fault at N+1
    valid_in_exu = 1'b1; alu_out = 32'h8000_0001; wmask = 8'h0F;
    mem_ren = 1'b1; mem_wen = 1'b0; func3 = 3'b010;
    tick();
    valid_in_exu = 1'b0;
    chk("mis_vout", valid_out_wbu, 1'b1);
    chk("mis_fault", fault_buf, 2'b01);
    chk("mis_noreq", mem_bus.mem_req_valid, 1'b0);
    tick();
    chk("mis_idle", ready_out_exu, 1'b1);

    // Request stall of 3 cycles, stray response during REQ, then access fault
    valid_in_exu = 1'b1; alu_out = 32'h8000_0010; mem_ren = 1'b1; mem_wen = 1'b0;
    func3 = 3'b010; mem_bus.mem_req_ready = 1'b0;
    tick();
    valid_in_exu = 1'b0;
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("stall_reqv", mem_bus.mem_req_valid, 1'b1);
      chk("stall_addr", mem_bus.mem_req_addr, 32'h8000_0010);
      chk("stall_wen", mem_bus.mem_req_wen, 1'b0);
      tick();
      mem_bus.mem_resp_valid = 1'b0;
    end
    chk("stall_reqv_end", mem_bus.mem_req_valid, 1'b1);
    mem_bus.mem_req_ready = 1'b1;
    tick();
    mem_bus.mem_req_ready = 1'b0;
    chk("stall_resp_wait", valid_out_wbu, 1'b0);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_err = 1'b1;
    mem_bus.mem_resp_rdata = 32'h1111_2222;
    tick();
    mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_err = 1'b0;
    chk("err_vout", valid_out_wbu, 1'b1);
    chk("err_fault", fault_buf, 2'b10);
    chk("err_result", result_buf, 32'h0);
    tick();

    // Reset while in RESP; a late response must be ignored
    valid_in_exu = 1'b1; alu_out = 32'h8000_0008; func3 = 3'b010;
    mem_bus.mem_req_ready = 1'b1;
    wb_info = 128'hAAAA;
    tick();
    valid_in_exu = 1'b0;
    tick();
    chk("rr_in_resp", mem_bus.mem_req_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rr_ready", ready_out_exu, 1'b1);
    chk("rr_vout", valid_out_wbu, 1'b0);
    chk("rr_wb", wb_info_buf, 128'h0);
    chk("rr_result", result_buf, 32'h0);
    tick();
    rst = 1'b1;
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'h7777_7777;
    tick();
    mem_bus.mem_resp_valid = 1'b0;
    chk("late_ready", ready_out_exu, 1'b1);
    chk("late_vout", valid_out_wbu, 1'b0);
    chk("late_result", result_buf, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store stage between the execute stage and the write-back stage. It takes one instruction at a time from the execute stage over a valid/ready handshake. For loads and stores it runs one request/response transaction on a data-memory port, aligning store data and strobes and sign/zero-extending load data. It then holds the result plus an opaque write-back bundle until the write-back stage accepts it.

## Interface
Reset: one clock; reset is asynchronous and active-low.

Parameters:
- WB_W, default 128: width of the opaque pass-through bundle (gpr_wen, rd, csr_wen, csr_waddr, csr_wdata, csr_out, pc, opcode, ben, is_ecall, is_mret).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- valid_in_exu  in  1  execute stage holds a valid instruction
- ready_out_exu  out  1  stage can accept; high only in IDLE
- alu_out  in  32  address for loads/stores, result otherwise
- wdata  in  32  store data, unshifted, low-aligned
- wmask  in  8  size mask; only [3:0] used (0x1 byte, 0x3 half, 0xF word); [7:4] ignored
- mem_ren  in  1  load
- mem_wen  in  1  store (mem_ren and mem_wen both high: treated as store)
- func3  in  3  load width/sign code
- wb_info  in  WB_W  pass-through bundle
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address (alu_out with [1:0] cleared)
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  32  wdata shifted left by 8*alu_out[1:0]
- mem_req_wstrb  out  4  wmask[3:0] shifted left by alu_out[1:0]
- mem_resp_valid  in  1  response valid (one-cycle pulse)
- mem_resp_rdata  in  32  read word
- mem_resp_err  in  1  access fault
- valid_out_wbu  out  1  result valid; high only in WAIT_WB
- ready_in_wbu  in  1  write-back stage accepts
- result_buf  out  32  extended load data, or alu_out for non-memory ops
- wb_info_buf  out  WB_W  registered wb_info
- fault_buf  out  2  00 none, 01 misaligned, 10 access fault

## Operation
- States: IDLE, REQ, RESP, WAIT_WB.
- IDLE, valid_in_exu=1: latch all inputs.
  - Non-memory op: next state WAIT_WB.
  - Misaligned memory op: next state WAIT_WB with fault 01 and no memory request. Misaligned means half with alu_out[0]=1, or word with alu_out[1:0]≠0.
  - Otherwise: next state REQ.
- REQ: mem_req_valid=1; request fields are stable from the latched values. On mem_req_ready, go to RESP.
- RESP: on mem_resp_valid, go to WAIT_WB.
  - Load: result = extract(mem_resp_rdata) by func3 and addr[1:0]:
    - 000 LB: sign-extend byte
    - 001 LH: sign-extend half
    - 100 LBU: zero-extend byte
    - 101 LHU: zero-extend half
    - 010 and all other codes: raw word
  - Store: result = alu_out.
  - mem_resp_err=1: fault 10 and result 0.
- WAIT_WB: hold all outputs. On ready_in_wbu, go to IDLE.
- Responses arriving outside RESP are ignored.

## Timing
- Reset (rst low, asynchronous):
  - state goes to IDLE
  - all _buf outputs go to 0
  - mem_req_valid=0, valid_out_wbu=0, ready_out_exu=1
  - any in-flight memory transaction is abandoned; the memory tolerates this.
- Non-memory op: accepted at edge N, valid_out_wbu high from cycle N+1.
- Load/store with zero-wait memory (ready in the first REQ cycle, response in the cycle after): accept N, REQ N+1, RESP N+2, valid_out_wbu from N+3.
- Latency grows one cycle per stall cycle of mem_req_ready or mem_resp_valid. No timeout.
- Throughput: at most one instruction every 2 cycles (IDLE is always visited between instructions).
- ready_out_exu and valid_out_wbu are pure state decodes (Moore); no combinational path from any input to either.
- mem_req_valid never drops before mem_req_ready is seen.

## Structure
- Package lsu_pkg holds:
  - state enum (IDLE/REQ/RESP/WAIT_WB)
  - func3 load constants
  - size-mask constants
  - fault codes
- Sub-module lsu_load_align: combinational extract/extend of rdata from func3 and addr[1:0]. It is unit-tested on its own.

## Test plan
- Non-memory op, alu_out=0x1234_5678, ready_in_wbu=1 → result_buf=0x1234_5678, valid_out_wbu high exactly 1 cycle, no mem_req_valid.
- LB at 0x8000_0003, rdata=0x80AA_BBCC, zero-wait memory → result_buf=0xFFFF_FF80, valid at N+3; LBU at the same address gives 0x0000_0080.
- SH at 0x8000_0002, wdata=0x0000_BEEF, wmask=0x03 → mem_req_addr=0x8000_0000, wstrb=4'b1100, wdata=0xBEEF_0000.
- LW at 0x8000_0001 → fault_buf=01, no memory request, valid at N+1.
- mem_req_ready held low 3 cycles, then the response arrives with mem_resp_err=1 → request fields stable throughout, fault_buf=10, result_buf=0.
- rst asserted while in RESP → next cycle ready_out_exu=1, outputs 0; a late mem_resp_valid is ignored.
